sr_icache: RTL and testbench
============================

SR_ICACHE -- requirements
Module: sr_icache

Interface
REQ-001 The block SHALL have parameter LINES, default 16, meaning the number of direct-mapped lines (power of two, at least 2).
REQ-002 The block SHALL have parameter LINE_WORDS, default 4, meaning the number of 32-bit words per line (power of two, at least 2).
REQ-003 The block SHALL have parameter CACHE_EN, default 1, meaning 1 = cache active and 0 = bypass.
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all logic is on posedge.
REQ-005 The block SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-006 The block SHALL have port im_req, input, width 1: CPU fetch request.
REQ-007 The block SHALL have port im_addr, input, width 32: CPU fetch byte address; bits [1:0] are ignored.
REQ-008 The block SHALL have port im_drdy, output, width 1: a one-cycle pulse meaning im_data is valid.
REQ-009 The block SHALL have port im_data, output, width 32: the fetched instruction.
REQ-010 The block SHALL have port mem_req, output, width 1: backing-memory word read request.
REQ-011 The block SHALL have port mem_addr, output, width 32: backing-memory word byte address, word-aligned.
REQ-012 The block SHALL have port mem_ack, input, width 1: one pulse per delivered word.
REQ-013 The block SHALL have port mem_rdata, input, width 32: the word delivered, valid when mem_ack=1.
REQ-014 The block SHALL have port miss_cnt, output, width 16: the count of misses since reset.

Function
REQ-015 Address split SHALL be: word offset = im_addr[log2(LINE_WORDS)+1:2]; index = the next log2(LINES) bits; tag = the remaining upper bits.
REQ-016 The FSM SHALL have states IDLE, LOOKUP, REFILL and RESP.
REQ-017 In IDLE, when im_req=1, the block SHALL capture im_addr and go to LOOKUP; im_req SHALL be ignored in every other state.
REQ-018 In LOOKUP, hit (valid[index] set and stored tag equals captured tag) SHALL load im_data from the array and go to RESP.
REQ-019 In LOOKUP, a miss SHALL increment miss_cnt, clear the word counter and go to REFILL.
REQ-020 RESP SHALL drive im_drdy=1 for exactly one cycle and then return to IDLE.
REQ-021 Hit latency: im_req accepted at edge N SHALL give im_drdy high in the cycle following edge N+2.
REQ-022 In REFILL, mem_req SHALL stay 1 continuously, with mem_addr = {tag, index, word counter, 2'b00}.
REQ-023 mem_addr SHALL stay stable until mem_ack is received.
REQ-024 On each mem_ack in REFILL, the block SHALL write mem_rdata into array[index][counter], latch it into im_data if counter equals the requested offset, and increment the counter.
REQ-025 The first request of a refill SHALL always be offset 0; there is no critical-word-first ordering.
REQ-026 On the ack of word LINE_WORDS-1, the block SHALL set valid[index], write the tag, drop mem_req in the next cycle and go to RESP.
REQ-027 mem_ack while mem_req=0 SHALL be ignored.
REQ-028 mem_ack arriving in the same cycle as mem_req first rises SHALL be accepted.
REQ-029 Refilling a valid line with a different tag SHALL overwrite it; the line SHALL only be re-validated on completion.
REQ-030 The word counter SHALL be log2(LINE_WORDS) bits wide, and its final increment SHALL wrap to 0.
REQ-031 With CACHE_EN=0, every access SHALL be a miss that issues one mem read at {im_addr[31:2],2'b00}, responds with that word, and updates no array or valid bit.
REQ-032 miss_cnt SHALL saturate at 0xFFFF.
REQ-033 im_data SHALL hold its value between pulses.

Reset
REQ-034 While rst=1, the block SHALL go to IDLE and drive im_drdy=0, mem_req=0, mem_addr=0, im_data=0 and miss_cnt=0.
REQ-035 While rst=1, the block SHALL clear all valid bits and the word counter; data and tag arrays are not reset.
REQ-036 Reset during REFILL SHALL abort the refill: mem_req SHALL be 0 in the cycle after the rst edge, the line SHALL stay invalid, and no im_drdy SHALL be issued.

Verification
REQ-037 Memory word at address A is 0x10000000+A/4, mem_ack is returned 1 cycle after mem_req, and defaults apply; after reset, fetch 0x00 -> mem_addr sequence 0x00,0x04,0x08,0x0C; im_drdy with im_data=0x10000000; miss_cnt=1.
REQ-038 Then fetch 0x08 -> im_drdy in the cycle following edge N+2; im_data=0x10000002; mem_req stays 0; miss_cnt=1.
REQ-039 Fetch 0x100 (index 0, new tag) -> refill 0x100..0x10C; im_data=0x10000040; a following fetch of 0x04 misses again; miss_cnt=3.
REQ-040 mem_ack delayed 3 cycles per word -> mem_req is held high and mem_addr is held stable across each wait; the refill takes 4 words; im_data is correct.
REQ-041 rst is pulsed after the 2nd ack of a refill of 0x200 -> mem_req=0 and im_drdy=0 the next cycle; miss_cnt=0; a following fetch of 0x200 misses and refills fully.
REQ-042 With CACHE_EN=0, fetch 0x0C twice -> two single-word reads at 0x0C; im_data=0x10000003 both times; miss_cnt=2.

Source files
------------

// File: rtl/sr_icache.sv
// Direct-mapped instruction cache with a word-serial refill port and a bypass mode.
// A fetch is captured in IDLE, looked up one cycle later, refilled from offset 0
// upward on a miss, and answered with a single registered im_drdy pulse.
module sr_icache #(
  parameter int unsigned LINES      = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned CACHE_EN   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        im_req,
  input  logic [31:0] im_addr,
  output logic        im_drdy,
  output logic [31:0] im_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [15:0] miss_cnt
);

  localparam int unsigned OW = $clog2(LINE_WORDS);
  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = 30 - OW - IW;
  localparam logic [OW-1:0] CntOne  = OW'(1);
  localparam logic [OW-1:0] CntLast = OW'(LINE_WORDS - 1);
  localparam bit Bypass = (CACHE_EN == 0);

  typedef enum logic [1:0] {StIdle, StLookup, StRefill, StResp} state_t;

  state_t          state_q, state_d;
  logic [31:2]     addr_q;
  logic [OW-1:0]   cnt_q;
  logic [LINES-1:0] valid_q;
  logic [TW-1:0]   tag_mem [LINES];
  logic [31:0]     data_mem [LINES*LINE_WORDS];
  logic [31:0]     im_data_q;
  logic            im_drdy_q;
  logic [15:0]     miss_q;

  logic [OW-1:0] req_off;
  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic          hit;
  logic          last_word;
  logic          take_word;

  assign req_off = addr_q[OW+1:2];
  assign req_idx = addr_q[OW+IW+1:OW+2];
  assign req_tag = addr_q[31:OW+IW+2];

  // Bypass never hits and always refills a single word.
  assign hit       = !Bypass && valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign last_word = Bypass || (cnt_q == CntLast);
  assign take_word = Bypass || (cnt_q == req_off);

  assign im_drdy  = im_drdy_q;
  assign im_data  = im_data_q;
  assign miss_cnt = miss_q;

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (im_req) state_d = StLookup;
      StLookup: state_d = hit ? StResp : StRefill;
      StRefill: if (mem_ack && last_word) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Refill request; address walks the line from offset 0 and holds until acked.
  always_comb begin
    mem_req  = (state_q == StRefill);
    mem_addr = '0;
    if (mem_req) begin
      mem_addr = Bypass ? {addr_q, 2'b00} : {addr_q[31:OW+2], cnt_q, 2'b00};
    end
  end

  // Control state, valid bits, response register and miss counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      cnt_q     <= '0;
      valid_q   <= '0;
      im_data_q <= '0;
      im_drdy_q <= 1'b0;
      miss_q    <= '0;
    end else begin
      state_q   <= state_d;
      // Registered so the pulse lands one cycle after RESP is entered.
      im_drdy_q <= (state_q == StResp);
      unique case (state_q)
        StIdle: begin
          if (im_req) addr_q <= im_addr[31:2];
        end
        StLookup: begin
          if (hit) begin
            im_data_q <= data_mem[{req_idx, req_off}];
          end else begin
            if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
            cnt_q <= '0;
            // Line is only trusted again once the whole refill lands.
            if (!Bypass) valid_q[req_idx] <= 1'b0;
          end
        end
        StRefill: begin
          if (mem_ack) begin
            if (take_word) im_data_q <= mem_rdata;
            cnt_q <= cnt_q + CntOne;
            if (last_word && !Bypass) valid_q[req_idx] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage; contents are don't-care until the valid bit is set.
  always_ff @(posedge clk) begin
    if (!rst && !Bypass && (state_q == StRefill) && mem_ack) begin
      data_mem[{req_idx, cnt_q}] <= mem_rdata;
      if (last_word) tag_mem[req_idx] <= req_tag;
    end
  end

endmodule

// File: tb/tb_sr_icache.sv
// Self-checking bench for sr_icache: one cached and one bypass instance share a
// behavioural backing memory; expectations come from a line/tag model of the cache.
module tb_sr_icache;

  localparam int unsigned LINES      = 16;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned LINE_BYTES = LINE_WORDS * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        im_req_c, im_req_b;
  logic [31:0] im_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        drdy_c, drdy_b, mreq_c, mreq_b;
  logic [31:0] data_c, data_b, maddr_c, maddr_b;
  logic [15:0] miss_c, miss_b;

  logic        sel_byp;
  logic        mreq, drdy;
  logic [31:0] maddr, data;
  logic [15:0] miss;

  assign mreq  = sel_byp ? mreq_b  : mreq_c;
  assign maddr = sel_byp ? maddr_b : maddr_c;
  assign drdy  = sel_byp ? drdy_b  : drdy_c;
  assign data  = sel_byp ? data_b  : data_c;
  assign miss  = sel_byp ? miss_b  : miss_c;

  always #5 clk = ~clk;

  sr_icache #(.LINES(LINES), .LINE_WORDS(LINE_WORDS), .CACHE_EN(1)) u_dut (
    .clk(clk), .rst(rst), .im_req(im_req_c), .im_addr(im_addr), .im_drdy(drdy_c),
    .im_data(data_c), .mem_req(mreq_c), .mem_addr(maddr_c), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .miss_cnt(miss_c)
  );

  sr_icache #(.LINES(LINES), .LINE_WORDS(LINE_WORDS), .CACHE_EN(0)) u_byp (
    .clk(clk), .rst(rst), .im_req(im_req_b), .im_addr(im_addr), .im_drdy(drdy_b),
    .im_data(data_b), .mem_req(mreq_b), .mem_addr(maddr_b), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .miss_cnt(miss_b)
  );

  int checks, errors;

  // Backing memory state
  int          ack_delay;
  bit          spur_en;
  int          wait_cnt;
  bit          ack_real;
  bit          consumed;
  logic [31:0] pend_addr;
  int          ack_total;
  int          stab_err;
  int          req_seen;
  bit          prev_req;
  logic [31:0] prev_addr;
  logic [31:0] log_q[$];

  // Reference model state
  bit          m_valid[LINES];
  logic [31:0] m_tag[LINES];
  int          m_miss_c, m_miss_b;
  logic [31:0] exp_log[$];
  bit          exp_hit;
  logic [31:0] exp_data;

  // Fetch results
  int          f_lat;
  logic [31:0] f_data;
  logic        f_drdy_next;
  logic [31:0] f_data_next;

  // Memory: word A holds 0x10000000 + A/4; acks ack_delay cycles after a request is seen.
  initial begin : mem_model
    mem_ack = 1'b0; mem_rdata = '0; wait_cnt = 0; ack_real = 1'b0; ack_total = 0;
    stab_err = 0; req_seen = 0; prev_req = 1'b0; prev_addr = '0; pend_addr = '0;
    forever begin
      @(posedge clk); #1;
      consumed = mem_ack && ack_real && !rst;
      if (consumed) begin
        ack_total++;
        log_q.push_back(pend_addr);
      end
      if (mreq === 1'b1 && prev_req && !consumed && maddr !== prev_addr) stab_err++;
      mem_ack = 1'b0; ack_real = 1'b0; mem_rdata = '0;
      if (mreq === 1'b1) begin
        req_seen++;
        if (wait_cnt >= ack_delay) begin
          mem_ack = 1'b1; ack_real = 1'b1; pend_addr = maddr;
          mem_rdata = 32'h1000_0000 + (maddr >> 2);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        if (spur_en && $urandom_range(0, 3) == 0) begin
          mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        end
      end
      prev_req  = (mreq === 1'b1);
      prev_addr = maddr;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_miss_c = 0;
    m_miss_b = 0;
  endtask

  task automatic model_fetch(input logic [31:0] a);
    int idx;
    logic [31:0] tag, base;
    idx  = int'((a / LINE_BYTES) % LINES);
    tag  = a / (LINE_BYTES * LINES);
    base = a - (a % LINE_BYTES);
    exp_log.delete();
    exp_data = 32'h1000_0000 + (a / 4);
    if (sel_byp) begin
      exp_hit = 1'b0;
      if (m_miss_b < 65535) m_miss_b++;
      exp_log.push_back(a & ~32'h3);
    end else if (m_valid[idx] && m_tag[idx] == tag) begin
      exp_hit = 1'b1;
    end else begin
      exp_hit = 1'b0;
      if (m_miss_c < 65535) m_miss_c++;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      for (int w = 0; w < LINE_WORDS; w++) exp_log.push_back(base + 32'(4 * w));
    end
  endtask

  function automatic bit log_ok();
    if (log_q.size() != exp_log.size()) return 1'b0;
    foreach (log_q[i]) if (log_q[i] !== exp_log[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Issue one fetch (entered #2 after an edge with the DUT idle); f_lat counts
  // sampled cycles after the accepting edge until im_drdy, -1 on timeout.
  task automatic fetch(input logic [31:0] a);
    log_q.delete();
    req_seen = 0;
    im_addr = a;
    if (sel_byp) im_req_b = 1'b1; else im_req_c = 1'b1;
    @(posedge clk); #2;
    im_req_c = 1'b0; im_req_b = 1'b0;
    im_addr = $urandom;
    f_lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #2;
      if (drdy === 1'b1) begin
        f_lat = k;
        break;
      end
    end
    f_data = data;
    @(posedge clk); #2;
    f_drdy_next = drdy;
    f_data_next = data;
  endtask

  task automatic test_reset();
    sel_byp = 1'b0; rst = 1'b1; im_req_c = 1'b0; im_req_b = 1'b0; im_addr = '0;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (drdy_c !== 1'b0) begin errors++; $display("FAIL reset_drdy got %b want 0", drdy_c); end
    checks++; if (mreq_c !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mreq_c); end
    checks++; if (maddr_c !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", maddr_c); end
    checks++; if (data_c !== 32'h0) begin errors++; $display("FAIL reset_im_data got %h want 0", data_c); end
    checks++; if (miss_c !== 16'h0) begin errors++; $display("FAIL reset_miss_cnt got %h want 0", miss_c); end
    checks++; if (miss_b !== 16'h0) begin errors++; $display("FAIL reset_byp_miss got %h want 0", miss_b); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_fill_and_hit();
    logic [31:0] addrs[4] = '{32'h00, 32'h08, 32'h100, 32'h04};
    sel_byp = 1'b0; ack_delay = 1; spur_en = 1'b0;
    foreach (addrs[i]) begin
      model_fetch(addrs[i]);
      fetch(addrs[i]);
      checks++; if (f_lat < 0 || f_data !== exp_data) begin errors++;
        $display("FAIL fill[%0d] data got %h (lat %0d) want %h", i, f_data, f_lat, exp_data); end
      checks++; if (!log_ok()) begin errors++;
        $display("FAIL fill[%0d] mem_seq got %0d words want %0d", i, log_q.size(), exp_log.size()); end
      checks++; if (miss !== 16'(m_miss_c)) begin errors++;
        $display("FAIL fill[%0d] miss_cnt got %0d want %0d", i, miss, m_miss_c); end
      if (exp_hit) begin
        checks++; if (f_lat != 2 || req_seen != 0) begin errors++;
          $display("FAIL fill[%0d] hit_latency got %0d req_cycles %0d want 2 and 0", i, f_lat, req_seen); end
        checks++; if (f_drdy_next !== 1'b0 || f_data_next !== f_data) begin errors++;
          $display("FAIL fill[%0d] pulse got drdy %b data %h want 0 and %h", i, f_drdy_next, f_data_next, f_data); end
      end
    end
    checks++; if (miss_c !== 16'd3 || data_c !== 32'h1000_0001) begin errors++;
      $display("FAIL fill_end got miss %0d data %h want 3 and 10000001", miss_c, data_c); end
  endtask

  task automatic test_slow_mem();
    logic [31:0] addrs[2] = '{32'h34, 32'h38};
    sel_byp = 1'b0; ack_delay = 3; spur_en = 1'b0; stab_err = 0;
    foreach (addrs[i]) begin
      model_fetch(addrs[i]);
      fetch(addrs[i]);
      checks++; if (f_lat < 0 || f_data !== exp_data) begin errors++;
        $display("FAIL slow[%0d] data got %h want %h", i, f_data, exp_data); end
      checks++; if (!log_ok()) begin errors++;
        $display("FAIL slow[%0d] mem_seq got %0d words want %0d", i, log_q.size(), exp_log.size()); end
    end
    checks++; if (stab_err != 0 || req_seen != 0) begin errors++;
      $display("FAIL slow mem_addr_stable got %0d changes, hit req %0d want 0", stab_err, req_seen); end
  endtask

  task automatic test_same_cycle_ack();
    logic [31:0] addrs[2] = '{32'h48, 32'h4C};
    sel_byp = 1'b0; ack_delay = 0; spur_en = 1'b0;
    foreach (addrs[i]) begin
      model_fetch(addrs[i]);
      fetch(addrs[i]);
      checks++; if (f_lat < 0 || f_data !== exp_data || !log_ok()) begin errors++;
        $display("FAIL fast[%0d] got data %h words %0d want %h words %0d",
                 i, f_data, log_q.size(), exp_data, exp_log.size()); end
    end
  endtask

  task automatic test_reset_abort();
    int base;
    bit seen_drdy;
    bit got2;
    sel_byp = 1'b0; ack_delay = 1; spur_en = 1'b0;
    base = ack_total;
    got2 = 1'b0;
    im_addr = 32'h200; im_req_c = 1'b1;
    @(posedge clk); #2;
    im_req_c = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #2;
      if (ack_total >= base + 2) begin
        got2 = 1'b1;
        break;
      end
    end
    checks++; if (!got2) begin errors++; $display("FAIL abort ack_wait got %0d acks want 2", ack_total - base); end
    rst = 1'b1;
    @(posedge clk); #2;
    checks++; if (mreq_c !== 1'b0 || drdy_c !== 1'b0) begin errors++;
      $display("FAIL abort outputs got mem_req %b drdy %b want 0 0", mreq_c, drdy_c); end
    checks++; if (miss_c !== 16'h0) begin errors++; $display("FAIL abort miss_cnt got %0d want 0", miss_c); end
    rst = 1'b0;
    model_reset();
    seen_drdy = 1'b0;
    repeat (6) begin
      @(posedge clk); #2;
      if (drdy_c !== 1'b0 || mreq_c !== 1'b0) seen_drdy = 1'b1;
    end
    checks++; if (seen_drdy) begin errors++; $display("FAIL abort quiet got activity want none"); end
    model_fetch(32'h200);
    fetch(32'h200);
    checks++; if (f_lat < 0 || f_data !== exp_data || !log_ok() || miss_c !== 16'(m_miss_c)) begin
      errors++;
      $display("FAIL abort refetch got data %h words %0d miss %0d want %h %0d %0d",
               f_data, log_q.size(), miss_c, exp_data, exp_log.size(), m_miss_c);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] addrs[4] = '{32'h0C, 32'h0C, 32'h0, 32'h0};
    addrs[2] = $urandom_range(0, 1023);
    addrs[3] = addrs[2];
    sel_byp = 1'b1; ack_delay = 1; spur_en = 1'b0;
    foreach (addrs[i]) begin
      model_fetch(addrs[i]);
      fetch(addrs[i]);
      checks++; if (f_lat < 0 || f_data !== exp_data) begin errors++;
        $display("FAIL byp[%0d] data got %h want %h", i, f_data, exp_data); end
      checks++; if (!log_ok() || miss !== 16'(m_miss_b)) begin errors++;
        $display("FAIL byp[%0d] got words %0d miss %0d want %0d %0d",
                 i, log_q.size(), miss, exp_log.size(), m_miss_b); end
      if (i == 1) begin
        checks++; if (miss_b !== 16'd2 || data_b !== 32'h1000_0003) begin errors++;
          $display("FAIL byp_twice got miss %0d data %h want 2 10000003", miss_b, data_b); end
      end
    end
    sel_byp = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a;
    spur_en = 1'b1; stab_err = 0;
    for (int i = 0; i < 80; i++) begin
      sel_byp   = ($urandom_range(0, 5) == 0);
      ack_delay = $urandom_range(0, 3);
      a = $urandom_range(0, 1023);
      model_fetch(a);
      fetch(a);
      checks++; if (f_lat < 0 || f_data !== exp_data) begin errors++;
        $display("FAIL rnd[%0d] addr %h data got %h want %h", i, a, f_data, exp_data); end
      checks++; if (!log_ok()) begin errors++;
        $display("FAIL rnd[%0d] addr %h mem_seq got %0d words want %0d", i, a, log_q.size(), exp_log.size()); end
      checks++; if (miss !== 16'(sel_byp ? m_miss_b : m_miss_c)) begin errors++;
        $display("FAIL rnd[%0d] miss_cnt got %0d want %0d", i, miss, sel_byp ? m_miss_b : m_miss_c); end
      checks++; if (f_drdy_next !== 1'b0 || f_data_next !== f_data) begin errors++;
        $display("FAIL rnd[%0d] pulse got drdy %b data %h", i, f_drdy_next, f_data_next); end
      if (exp_hit) begin
        checks++; if (f_lat != 2 || req_seen != 0) begin errors++;
          $display("FAIL rnd[%0d] hit_latency got %0d req_cycles %0d want 2 0", i, f_lat, req_seen); end
      end
    end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL rnd mem_addr_stable got %0d changes want 0", stab_err); end
    spur_en = 1'b0;
    sel_byp = 1'b0;
  endtask

  initial begin : main
    checks = 0; errors = 0;
    sel_byp = 1'b0; ack_delay = 1; spur_en = 1'b0;
    rst = 1'b1; im_req_c = 1'b0; im_req_b = 1'b0; im_addr = '0;
    test_reset();
    test_fill_and_hit();
    test_slow_mem();
    test_same_cycle_ack();
    test_reset_abort();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
